// File: rtl/vga_timing_scaler.sv
// VGA raster generator with integer zoom from a sub-resolution RGB12 frame buffer.
// Counters drive buffer addresses; sync/blank are delayed to line up with the returned pixel data.
module vga_timing_scaler #(
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   H_ACT      = 640,
    parameter int   H_FP       = 16,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   V_ACT      = 480,
    parameter int   V_FP       = 10,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   ZOOM_LOG2  = 1,
    parameter int   BUF_HRES   = H_ACT >> ZOOM_LOG2,
    parameter int   ADDR_W     = 17,
    parameter int   RD_LATENCY = 1
) (
    input  logic              piul1Clock,
    input  logic              piul1Reset_n,
    input  logic              piul1Enable,
    output logic [ADDR_W-1:0] poulRAddr,
    input  logic [11:0]       piul12RData,
    output logic              poul1HSync,
    output logic              poul1VSync,
    output logic              poul1Blank_n,
    output logic [7:0]        poul8Red,
    output logic [7:0]        poul8Green,
    output logic [7:0]        poul8Blue,
    output logic              poul1FrameStart
);

    localparam int     H_TOT     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int     V_TOT     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int     H_W       = $clog2(H_TOT);
    localparam int     V_W       = $clog2(V_TOT);
    localparam int     SUB_W     = (ZOOM_LOG2 > 0) ? ZOOM_LOG2 : 1;
    localparam int     PIPE      = RD_LATENCY + 2;
    localparam longint LAST_ADDR = longint'(BUF_HRES) * longint'(V_ACT >> ZOOM_LOG2) - 1;

    localparam logic [H_W-1:0]    H_SYNC_END  = H_W'(H_SYNC);
    localparam logic [H_W-1:0]    H_ACT_BEG   = H_W'(H_SYNC + H_BP);
    localparam logic [H_W-1:0]    H_ACT_LAST  = H_W'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [H_W-1:0]    H_LAST      = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0]    V_SYNC_END  = V_W'(V_SYNC);
    localparam logic [V_W-1:0]    V_ACT_BEG   = V_W'(V_SYNC + V_BP);
    localparam logic [V_W-1:0]    V_ACT_LAST  = V_W'(V_SYNC + V_BP + V_ACT - 1);
    localparam logic [V_W-1:0]    V_LAST      = V_W'(V_TOT - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST    = SUB_W'((1 << ZOOM_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(BUF_HRES);

    generate
        if ((H_ACT % (1 << ZOOM_LOG2)) != 0 || (V_ACT % (1 << ZOOM_LOG2)) != 0) begin : gBadZoom
            $error("vga_timing_scaler: H_ACT and V_ACT must be multiples of 2**ZOOM_LOG2");
        end
        if (ADDR_W < 63 && LAST_ADDR >= (longint'(1) << ADDR_W)) begin : gBadAddrW
            $error("vga_timing_scaler: ADDR_W too narrow for the last buffer address");
        end
        if (RD_LATENCY < 1) begin : gBadLatency
            $error("vga_timing_scaler: RD_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} stateT;

    stateT            state, stateNext;
    logic [H_W-1:0]   hCnt;
    logic [V_W-1:0]   vCnt;
    logic             running, hLast, vLast, frameWrap;
    logic             hAct, vAct, display, lineEnd;
    logic             hsRaw, vsRaw, fsRaw;

    assign running   = (state == RUN);
    assign hLast     = (hCnt == H_LAST);
    assign vLast     = (vCnt == V_LAST);
    assign frameWrap = running && hLast && vLast;
    assign hAct      = (hCnt >= H_ACT_BEG) && (hCnt <= H_ACT_LAST);
    assign vAct      = (vCnt >= V_ACT_BEG) && (vCnt <= V_ACT_LAST);
    assign display   = running && hAct && vAct;
    assign lineEnd   = display && (hCnt == H_ACT_LAST);
    assign hsRaw     = (running && hCnt < H_SYNC_END) ? HS_POL : ~HS_POL;
    assign vsRaw     = (running && vCnt < V_SYNC_END) ? VS_POL : ~VS_POL;
    assign fsRaw     = running && (hCnt == H_ACT_BEG) && (vCnt == V_ACT_BEG);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) state <= IDLE;
        else               state <= stateNext;
    end

    // NOTE: stateNext gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (piul1Enable) stateNext = RUN;
            RUN:     if (frameWrap && !piul1Enable) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (!running) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hLast) begin
            hCnt <= '0;
            vCnt <= vLast ? '0 : vCnt + V_W'(1);
        end else begin
            hCnt <= hCnt + H_W'(1);
        end
    end

    // Incremental address walk: xSub/ySub count repeats of a buffer pixel and row.
    logic [ADDR_W-1:0] rowBase, pixAddr;
    logic [SUB_W-1:0]  xSub, ySub;

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            poulRAddr <= '0;
            rowBase   <= '0;
            pixAddr   <= '0;
            xSub      <= '0;
            ySub      <= '0;
        end else begin
            if (display) begin
                poulRAddr <= pixAddr;
                if (lineEnd) begin
                    xSub <= '0;
                    if (ySub != SUB_LAST) begin
                        ySub    <= ySub + SUB_W'(1);
                        pixAddr <= rowBase;
                    end else begin
                        ySub    <= '0;
                        rowBase <= rowBase + ROW_STEP;
                        pixAddr <= rowBase + ROW_STEP;
                    end
                end else if (xSub == SUB_LAST) begin
                    xSub    <= '0;
                    pixAddr <= pixAddr + ADDR_W'(1);
                end else begin
                    xSub <= xSub + SUB_W'(1);
                end
            end
            if (!running || frameWrap) begin
                rowBase <= '0;
                pixAddr <= '0;
                xSub    <= '0;
                ySub    <= '0;
            end
        end
    end

    // Timing delay line, RD_LATENCY+2 deep, so controls leave together with the RGB they belong to.
    logic [PIPE-1:0] hsPipe, vsPipe, actPipe, fsPipe;

    // NOTE: these are plain flops, not a RAM, so they take the async reset and outputs idle at once.
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            hsPipe  <= {PIPE{~HS_POL}};
            vsPipe  <= {PIPE{~VS_POL}};
            actPipe <= '0;
            fsPipe  <= '0;
        end else begin
            hsPipe  <= {hsPipe[PIPE-2:0], hsRaw};
            vsPipe  <= {vsPipe[PIPE-2:0], vsRaw};
            actPipe <= {actPipe[PIPE-2:0], display};
            fsPipe  <= {fsPipe[PIPE-2:0], fsRaw};
        end
    end

    assign poul1HSync      = hsPipe[PIPE-1];
    assign poul1VSync      = vsPipe[PIPE-1];
    assign poul1Blank_n    = actPipe[PIPE-1];
    assign poul1FrameStart = fsPipe[PIPE-1];

    // actPipe[PIPE-2] is the blank flag that moves to the output on this same edge.
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            poul8Red   <= '0;
            poul8Green <= '0;
            poul8Blue  <= '0;
        end else if (actPipe[PIPE-2]) begin
            poul8Red   <= {piul12RData[11:8], piul12RData[11:8]};
            poul8Green <= {piul12RData[7:4],  piul12RData[7:4]};
            poul8Blue  <= {piul12RData[3:0],  piul12RData[3:0]};
        end else begin
            poul8Red   <= '0;
            poul8Green <= '0;
            poul8Blue  <= '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_scaler.sv
// Directed bench for vga_timing_scaler: three instances (default 640x480 zoom 2, small 1:1
// active-high, small zoom 2 with latency 3) compared cycle by cycle against hand-built raster shapes.
module tb_vga_timing_scaler;

    typedef struct {
        int hS, hB, hA, hF, vS, vB, vA, vF, zl, lat;
        bit hp, vp, constData;
    } cfgT;

    logic clk = 1'b0;
    logic rst_n;
    logic en [3];

    logic [16:0] addr [3];
    logic        hs [3], vs [3], bl [3], fs [3];
    logic [7:0]  r [3], g [3], b [3];
    logic [27:0] obs [3];
    logic [11:0] rdA, rdB, rdC;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    // Buffer models: A and B return addr[11:0] one clock late, C returns a constant.
    always @(posedge clk) rdA <= addr[0][11:0];
    always @(posedge clk) rdB <= addr[1][11:0];
    assign rdC = 12'hA5C;

    assign obs[0] = {hs[0], vs[0], bl[0], fs[0], r[0], g[0], b[0]};
    assign obs[1] = {hs[1], vs[1], bl[1], fs[1], r[1], g[1], b[1]};
    assign obs[2] = {hs[2], vs[2], bl[2], fs[2], r[2], g[2], b[2]};

    vga_timing_scaler dutA (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en[0]),
        .poulRAddr(addr[0]), .piul12RData(rdA),
        .poul1HSync(hs[0]), .poul1VSync(vs[0]), .poul1Blank_n(bl[0]),
        .poul8Red(r[0]), .poul8Green(g[0]), .poul8Blue(b[0]), .poul1FrameStart(fs[0])
    );

    vga_timing_scaler #(
        .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4), .V_SYNC(1), .V_BP(1), .V_ACT(8), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .ZOOM_LOG2(0), .RD_LATENCY(1)
    ) dutB (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en[1]),
        .poulRAddr(addr[1]), .piul12RData(rdB),
        .poul1HSync(hs[1]), .poul1VSync(vs[1]), .poul1Blank_n(bl[1]),
        .poul8Red(r[1]), .poul8Green(g[1]), .poul8Blue(b[1]), .poul1FrameStart(fs[1])
    );

    vga_timing_scaler #(
        .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4), .V_SYNC(1), .V_BP(1), .V_ACT(8), .V_FP(1),
        .ZOOM_LOG2(1), .RD_LATENCY(3)
    ) dutC (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en[2]),
        .poulRAddr(addr[2]), .piul12RData(rdC),
        .poul1HSync(hs[2]), .poul1VSync(vs[2]), .poul1Blank_n(bl[2]),
        .poul8Red(r[2]), .poul8Green(g[2]), .poul8Blue(b[2]), .poul1FrameStart(fs[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic cfgT cfgOf(input int id);
        cfgT c;
        case (id)
            0:       c = '{96, 48, 640, 16, 2, 33, 480, 10, 1, 1, 1'b0, 1'b0, 1'b0};
            1:       c = '{4, 4, 16, 4, 1, 1, 8, 1, 0, 1, 1'b1, 1'b1, 1'b0};
            default: c = '{4, 4, 16, 4, 1, 1, 8, 1, 1, 3, 1'b0, 1'b0, 1'b1};
        endcase
        return c;
    endfunction

    function automatic int addrOf(input cfgT c, input int x, input int y);
        return (y >> c.zl) * (c.hA >> c.zl) + (x >> c.zl);
    endfunction

    function automatic logic [27:0] idleVec(input cfgT c);
        return {~c.hp, ~c.vp, 1'b0, 1'b0, 24'h0};
    endfunction

    // Expected {hsync, vsync, blank_n, frameStart, R, G, B} for raster position n of a running frame.
    function automatic logic [27:0] pixVec(input cfgT c, input int n);
        int hT, vT, h, v, x, y;
        logic disp, hsE, vsE, fsE;
        logic [11:0] d;
        logic [23:0] rgb;
        hT   = c.hS + c.hB + c.hA + c.hF;
        vT   = c.vS + c.vB + c.vA + c.vF;
        h    = n % hT;
        v    = (n / hT) % vT;
        x    = h - (c.hS + c.hB);
        y    = v - (c.vS + c.vB);
        disp = (x >= 0) && (x < c.hA) && (y >= 0) && (y < c.vA);
        hsE  = (h < c.hS) ? c.hp : ~c.hp;
        vsE  = (v < c.vS) ? c.vp : ~c.vp;
        fsE  = (x == 0) && (y == 0);
        d    = c.constData ? 12'hA5C : 12'(addrOf(c, x, y));
        rgb  = disp ? {d[11:8], d[11:8], d[7:4], d[7:4], d[3:0], d[3:0]} : 24'h0;
        return {hsE, vsE, disp, fsE, rgb};
    endfunction

    // Caller raises en[id] on a negedge just before calling. Raster position 0 reaches the outputs
    // after lat+2 edges and the read address after one; enable drops at negedge dropAt (0 = never).
    task automatic runDut(input int id, input int frames, input int dropAt, input int cycles,
                          output int maxObs);
        cfgT c;
        int hT, vT, ft, n, m, h, v, x, y, a;
        logic [27:0] e;
        c      = cfgOf(id);
        hT     = c.hS + c.hB + c.hA + c.hF;
        vT     = c.vS + c.vB + c.vA + c.vF;
        ft     = hT * vT;
        maxObs = -1;
        for (int j = 1; j <= cycles; j++) begin
            @(negedge clk);
            if (j == dropAt) en[id] = 1'b0;
            n = j - (c.lat + 3);
            e = (n >= 0 && n < frames * ft) ? pixVec(c, n) : idleVec(c);
            check($sformatf("dut%0d video cyc %0d", id, j), 32'(obs[id]), 32'(e));
            m = j - 2;
            if (m >= 0 && m < frames * ft) begin
                h = m % hT;
                v = (m / hT) % vT;
                x = h - (c.hS + c.hB);
                y = v - (c.vS + c.vB);
                if (x >= 0 && x < c.hA && y >= 0 && y < c.vA) begin
                    a = addrOf(c, x, y);
                    check($sformatf("dut%0d raddr cyc %0d", id, j), 32'(addr[id]), 32'(a));
                    if (int'(addr[id]) > maxObs) maxObs = int'(addr[id]);
                end
            end
        end
    endtask

    initial begin
        int maxA;
        rst_n = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        en[2] = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset video dut%0d", i), 32'(obs[i]), 32'(idleVec(cfgOf(i))));
            check($sformatf("reset raddr dut%0d", i), 32'(addr[i]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Default 640x480: sync/blank shape and zoomed addresses through active line 2.
        en[0] = 1'b1;
        runDut(0, 1, 0, 4 + 38 * 800 - 1, maxA);
        en[0] = 1'b0;

        // Small 1:1 raster with active-high syncs: linear addresses 0..127.
        en[1] = 1'b1;
        runDut(1, 1, 154, 4 + 308 + 10, maxA);
        check("dutB last raddr", 32'(maxA), 32'd127);

        // Zoom 2, latency 3: enable drops mid second frame, that frame completes, then idle.
        en[2] = 1'b1;
        runDut(2, 2, 308 + 154, 6 + 616 + 20, maxA);
        check("dutC last raddr", 32'(maxA), 32'd31);

        // Re-enable from IDLE: hsync goes active exactly when raster position 0 reaches the output.
        en[2] = 1'b1;
        runDut(2, 1, 154, 6 + 308 + 20, maxA);

        // Async reset in the middle of an active line, checked before any clock edge.
        en[2] = 1'b1;
        repeat (102) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset video", 32'(obs[2]), 32'(idleVec(cfgOf(2))));
        check("async reset raddr", 32'(addr[2]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runDut(2, 1, 154, 6 + 308 + 20, maxA);
        check("dutC last raddr after reset", 32'(maxA), 32'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
